// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock/frequency supervisor on the CLKI domain; releases system reset once CLKOS is qualified.
// Retries a failed bring-up up to MAX_RETRIES times, then parks in a sticky FAIL state.
module pll_reset_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 4096,
  parameter int unsigned STABLE_CYCLES = 256,
  parameter int unsigned MEAS_WINDOW   = 1024,
  parameter int unsigned EXP_EDGES     = 256,
  parameter int unsigned TOL           = 2,
  parameter int unsigned MAX_RETRIES   = 3,
  parameter int unsigned RETRY_W       = 2
) (
  input  logic               CLKI,
  input  logic               RSTN,
  input  logic               PLL_LOCK,
  input  logic               CLKOS_TGL,
  output logic               PLL_RST,
  output logic               CLK_READY,
  output logic               SYS_RSTN,
  output logic               FAIL,
  output logic [RETRY_W-1:0] RETRY_CNT,
  output logic [2:0]         STATE
);

  localparam int unsigned MAX_A  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_B  = (STABLE_CYCLES > MEAS_WINDOW) ? STABLE_CYCLES : MEAS_WINDOW;
  localparam int unsigned MAX_P  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CYC_W  = $clog2(MAX_P + 1);
  localparam int unsigned EDGE_W = $clog2(MEAS_WINDOW + 1);
  localparam int unsigned TOL_LO = (EXP_EDGES > TOL) ? (EXP_EDGES - TOL) : 0;
  localparam int unsigned TOL_HI = EXP_EDGES + TOL;

  localparam logic [CYC_W-1:0]   RST_LAST    = CYC_W'(RST_CYCLES - 1);
  localparam logic [CYC_W-1:0]   LOCK_LAST   = CYC_W'(LOCK_TIMEOUT - 1);
  localparam logic [CYC_W-1:0]   STABLE_LAST = CYC_W'(STABLE_CYCLES - 1);
  localparam logic [CYC_W-1:0]   MEAS_LAST   = CYC_W'(MEAS_WINDOW - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET     = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_MEASURE   = 3'd3,
    S_RUN       = 3'd4,
    S_RETRY     = 3'd5,
    S_FAIL      = 3'd6
  } state_t;

  state_t              state, state_next;
  logic                lock_m, lock_s, tgl_m, tgl_s, tgl_q;
  logic [CYC_W-1:0]    cyc_cnt;
  logic [EDGE_W-1:0]   edge_cnt, edge_total;
  logic [RETRY_W-1:0]  retry_cnt;
  logic                edge_seen, in_tol;
  logic                pll_rst_d, clk_ready_d, sys_rstn_d, fail_d;

  always_ff @(posedge CLKI or negedge RSTN) begin
    if (!RSTN) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
      tgl_m  <= 1'b0;
      tgl_s  <= 1'b0;
      tgl_q  <= 1'b0;
    end else begin
      lock_m <= PLL_LOCK;
      lock_s <= lock_m;
      tgl_m  <= CLKOS_TGL;
      tgl_s  <= tgl_m;
      tgl_q  <= tgl_s;
    end
  end

  assign edge_seen  = tgl_s ^ tgl_q;
  // Window verdict includes an edge landing in the final window cycle.
  assign edge_total = (edge_seen && (edge_cnt != '1)) ? edge_cnt + 1'b1 : edge_cnt;
  assign in_tol     = (32'(edge_total) >= TOL_LO) && (32'(edge_total) <= TOL_HI);

  always_ff @(posedge CLKI or negedge RSTN) begin
    if (!RSTN) begin
      state <= S_RESET;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_RESET:     if (cyc_cnt == RST_LAST) state_next = S_WAIT_LOCK;
      S_WAIT_LOCK: if (lock_s) state_next = S_STABLE;
                   else if (cyc_cnt == LOCK_LAST) state_next = S_RETRY;
      S_STABLE:    if (!lock_s) state_next = S_RETRY;
                   else if (cyc_cnt == STABLE_LAST) state_next = S_MEASURE;
      S_MEASURE:   if (!lock_s) state_next = S_RETRY;
                   else if (cyc_cnt == MEAS_LAST) state_next = in_tol ? S_RUN : S_RETRY;
      S_RUN:       if (!lock_s) state_next = S_RETRY;
      S_RETRY:     state_next = (retry_cnt == RETRY_MAX) ? S_FAIL : S_RESET;
      S_FAIL:      state_next = S_FAIL;
      default:     state_next = S_RESET;
    endcase
  end

  always_ff @(posedge CLKI or negedge RSTN) begin
    if (!RSTN) begin
      cyc_cnt   <= '0;
      edge_cnt  <= '0;
      retry_cnt <= '0;
    end else begin
      if (state_next != state) begin
        cyc_cnt  <= '0;
        edge_cnt <= '0;
      end else begin
        if (cyc_cnt != '1) cyc_cnt <= cyc_cnt + 1'b1;
        if ((state == S_MEASURE) && edge_seen && (edge_cnt != '1)) edge_cnt <= edge_cnt + 1'b1;
      end
      if ((state == S_RETRY) && (state_next == S_RESET)) retry_cnt <= retry_cnt + 1'b1;
    end
  end

  // Outputs decode the next state so they are valid in the first cycle of each state.
  always_comb begin
    pll_rst_d   = 1'b0;
    clk_ready_d = 1'b0;
    sys_rstn_d  = 1'b0;
    fail_d      = 1'b0;
    case (state_next)
      S_RESET, S_RETRY: pll_rst_d = 1'b1;
      S_RUN: begin
        clk_ready_d = 1'b1;
        sys_rstn_d  = 1'b1;
      end
      S_FAIL: begin
        pll_rst_d = 1'b1;
        fail_d    = 1'b1;
      end
      default: pll_rst_d = 1'b0;
    endcase
  end

  always_ff @(posedge CLKI or negedge RSTN) begin
    if (!RSTN) begin
      PLL_RST   <= 1'b1;
      CLK_READY <= 1'b0;
      SYS_RSTN  <= 1'b0;
      FAIL      <= 1'b0;
    end else begin
      PLL_RST   <= pll_rst_d;
      CLK_READY <= clk_ready_d;
      SYS_RSTN  <= sys_rstn_d;
      FAIL      <= fail_d;
    end
  end

  assign RETRY_CNT = retry_cnt;
  assign STATE     = state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: state durations, retry/fail paths, edge tolerance, async reset.
module tb_pll_reset_sequencer;

  logic       CLKI = 1'b0;
  logic       RSTN, PLL_LOCK, CLKOS_TGL;
  logic       PLL_RST, CLK_READY, SYS_RSTN, FAIL;
  logic [1:0] RETRY_CNT;
  logic [2:0] STATE;

  typedef struct {
    string       tag;
    int unsigned exp;
  } exp_t;

  exp_t        sb[$];
  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  int unsigned tgl_period = 0;
  int unsigned burst_k    = 0;
  int unsigned per_cnt    = 0;
  int unsigned w          = 0;
  int unsigned sent       = 0;
  bit          in_meas    = 1'b0;

  pll_reset_sequencer #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (32),
    .STABLE_CYCLES (8),
    .MEAS_WINDOW   (64),
    .EXP_EDGES     (16),
    .TOL           (1),
    .MAX_RETRIES   (2),
    .RETRY_W       (2)
  ) dut (
    .CLKI      (CLKI),
    .RSTN      (RSTN),
    .PLL_LOCK  (PLL_LOCK),
    .CLKOS_TGL (CLKOS_TGL),
    .PLL_RST   (PLL_RST),
    .CLK_READY (CLK_READY),
    .SYS_RSTN  (SYS_RSTN),
    .FAIL      (FAIL),
    .RETRY_CNT (RETRY_CNT),
    .STATE     (STATE)
  );

  always #5 CLKI = ~CLKI;

  // CLKOS/N toggle source: free-running every tgl_period cycles, or a burst of
  // burst_k toggles spaced 4 cycles apart starting 4 cycles into each measure window.
  always @(negedge CLKI) begin
    if (tgl_period != 0) begin
      per_cnt++;
      if (per_cnt >= tgl_period) begin
        per_cnt   = 0;
        CLKOS_TGL = ~CLKOS_TGL;
      end
    end else if (burst_k != 0) begin
      if (STATE != 3'd3) begin
        in_meas = 1'b0;
        w       = 0;
        sent    = 0;
      end else begin
        if (in_meas) w++;
        else in_meas = 1'b1;
        if ((w != 0) && (w % 4 == 0) && (sent < burst_k)) begin
          CLKOS_TGL = ~CLKOS_TGL;
          sent++;
        end
      end
    end
  end

  task automatic expect_val(input string tag, input int unsigned v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic compare_next(input int unsigned obs);
    exp_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty: observed %0d, nothing expected", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        miscompares++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic expect_outs(input string tag, input int unsigned st, input int unsigned pr,
                             input int unsigned cr, input int unsigned sr,
                             input int unsigned fl, input int unsigned rc);
    expect_val({tag, ".STATE"}, st);
    expect_val({tag, ".PLL_RST"}, pr);
    expect_val({tag, ".CLK_READY"}, cr);
    expect_val({tag, ".SYS_RSTN"}, sr);
    expect_val({tag, ".FAIL"}, fl);
    expect_val({tag, ".RETRY_CNT"}, rc);
  endtask

  task automatic compare_outs();
    compare_next(32'(STATE));
    compare_next(32'(PLL_RST));
    compare_next(32'(CLK_READY));
    compare_next(32'(SYS_RSTN));
    compare_next(32'(FAIL));
    compare_next(32'(RETRY_CNT));
  endtask

  task automatic check_outs(input string tag, input int unsigned st, input int unsigned pr,
                            input int unsigned cr, input int unsigned sr,
                            input int unsigned fl, input int unsigned rc);
    expect_outs(tag, st, pr, cr, sr, fl, rc);
    compare_outs();
  endtask

  // Counts consecutive negedge samples (current one included) with STATE==s.
  task automatic count_state(input logic [2:0] s, output int unsigned n);
    n = 0;
    while ((STATE == s) && (n < 500)) begin
      n++;
      @(negedge CLKI);
    end
  endtask

  task automatic chk_len(input string tag, input logic [2:0] s, input int unsigned exp_n);
    int unsigned n;
    expect_val(tag, exp_n);
    count_state(s, n);
    compare_next(n);
  endtask

  initial begin
    int unsigned n;
    RSTN      = 1'b1;
    PLL_LOCK  = 1'b0;
    CLKOS_TGL = 1'b0;
    #1 RSTN = 1'b0;
    #2 check_outs("por", 0, 1, 0, 0, 0, 0);

    // Nominal bring-up with late lock and CLKOS_TGL every 4 cycles
    tgl_period = 4;
    repeat (3) @(negedge CLKI);
    RSTN = 1'b1;
    chk_len("nom.reset_len", 3'd0, 4);
    check_outs("nom.wait_entry", 1, 0, 0, 0, 0, 0);
    expect_val("nom.wait_len", 13);
    repeat (10) @(negedge CLKI);
    PLL_LOCK = 1'b1;
    count_state(3'd1, n);
    compare_next(n + 10);
    chk_len("nom.stable_len", 3'd2, 8);
    chk_len("nom.measure_len", 3'd3, 64);
    check_outs("nom.run", 4, 0, 1, 1, 0, 0);

    // Lock loss in S_RUN
    repeat (5) @(negedge CLKI);
    PLL_LOCK = 1'b0;
    chk_len("drop.run_tail", 3'd4, 3);
    check_outs("drop.retry", 5, 1, 0, 0, 0, 0);
    chk_len("drop.retry_len", 3'd5, 1);
    chk_len("drop.reset_len", 3'd0, 4);
    check_outs("drop.wait", 1, 0, 0, 0, 0, 1);

    // One-cycle lock glitch 5 cycles into S_STABLE, coinciding with stable timeout
    PLL_LOCK = 1'b1;
    chk_len("glitch.wait_len", 3'd1, 3);
    repeat (5) @(negedge CLKI);
    PLL_LOCK = 1'b0;
    @(negedge CLKI);
    PLL_LOCK = 1'b1;
    chk_len("glitch.stable_tail", 3'd2, 2);
    check_outs("glitch.retry", 5, 1, 0, 0, 0, 1);
    chk_len("glitch.retry_len", 3'd5, 1);
    chk_len("glitch.reset_len", 3'd0, 4);
    chk_len("clean.wait_len", 3'd1, 1);
    chk_len("clean.stable_len", 3'd2, 8);
    chk_len("clean.measure_len", 3'd3, 64);
    check_outs("clean.run", 4, 0, 1, 1, 0, 2);

    // Retries exhausted: lock loss in S_RUN goes to S_FAIL
    PLL_LOCK = 1'b0;
    chk_len("exhaust.run_tail", 3'd4, 3);
    chk_len("exhaust.retry_len", 3'd5, 1);
    check_outs("exhaust.fail", 6, 1, 0, 0, 1, 2);

    // Async reset out of S_FAIL, then lock never asserts
    #2 RSTN = 1'b0;
    #1 check_outs("rst_from_fail", 0, 1, 0, 0, 0, 0);
    @(negedge CLKI);
    RSTN = 1'b1;
    for (int unsigned a = 0; a < 3; a++) begin
      chk_len("nolock.reset_len", 3'd0, 4);
      chk_len("nolock.wait_len", 3'd1, 32);
      chk_len("nolock.retry_len", 3'd5, 1);
    end
    check_outs("nolock.fail", 6, 1, 0, 0, 1, 2);
    repeat (20) @(negedge CLKI);
    PLL_LOCK = 1'b1;
    repeat (5) @(negedge CLKI);
    check_outs("nolock.fail_held", 6, 1, 0, 0, 1, 2);

    // Frequency window: ~21 edges fail, 14 edges fail, then reset mid-measure
    #2 RSTN = 1'b0;
    tgl_period = 3;
    @(negedge CLKI);
    RSTN = 1'b1;
    chk_len("fast.reset_len", 3'd0, 4);
    chk_len("fast.wait_len", 3'd1, 1);
    chk_len("fast.stable_len", 3'd2, 8);
    chk_len("fast.measure_len", 3'd3, 64);
    check_outs("fast.retry", 5, 1, 0, 0, 0, 0);
    tgl_period = 0;
    burst_k    = 14;
    chk_len("e14.retry_len", 3'd5, 1);
    chk_len("e14.reset_len", 3'd0, 4);
    chk_len("e14.wait_len", 3'd1, 1);
    chk_len("e14.stable_len", 3'd2, 8);
    chk_len("e14.measure_len", 3'd3, 64);
    check_outs("e14.retry", 5, 1, 0, 0, 0, 1);
    burst_k = 15;
    chk_len("midrst.retry_len", 3'd5, 1);
    chk_len("midrst.reset_len", 3'd0, 4);
    check_outs("midrst.wait", 1, 0, 0, 0, 0, 2);
    chk_len("midrst.wait_len", 3'd1, 1);
    chk_len("midrst.stable_len", 3'd2, 8);
    repeat (20) @(negedge CLKI);
    #2 RSTN = 1'b0;
    #1 check_outs("midrst.async", 0, 1, 0, 0, 0, 0);

    // Restart after reset: exactly 15 edges sits on the tolerance bound and passes
    @(negedge CLKI);
    RSTN = 1'b1;
    chk_len("e15.reset_len", 3'd0, 4);
    chk_len("e15.wait_len", 3'd1, 1);
    chk_len("e15.stable_len", 3'd2, 8);
    chk_len("e15.measure_len", 3'd3, 64);
    check_outs("e15.run", 4, 0, 1, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
